ps2_key_sequencer: RTL and testbench
====================================

# ps2_key_sequencer

Controller that sequences the PS/2 receive FIFO (`ready`/`nextdata_n` pop handshake) and turns its raw scan-code byte stream into key events.
- Strips the set-2 `E0` (extended) and `F0` (break) prefixes.
- Suppresses typematic repeats of the held key.
- Counts key presses.
- Hands each event to downstream logic (ASCII lookup, display, CPU MMIO) over a valid/ready port.

It sits directly between the PS/2 receiver FIFO and all keyboard consumers, and is the only block that pops that FIFO.

## Interface
- `CNT_W`, default 8: width of the key-press counter.

- `clk`  in  1  system clock; same clock as the receive FIFO.
- `clrn`  in  1  reset, asynchronous, active-low.
- `ready`  in  1  FIFO non-empty; `data` valid while high.
- `data`  in  8  FIFO head byte.
- `nextdata_n`  out  1  FIFO pop strobe, active-low, exactly one cycle per byte.
- `ev_valid`  out  1  key event available.
- `ev_ready`  in  1  consumer accepts event.
- `ev_code`  out  8  scan code of the event, prefixes removed.
- `ev_ext`  out  1  event was `E0`-prefixed.
- `ev_break`  out  1  1 = release, 0 = press.
- `held`  out  1  a key is currently held.
- `held_code`  out  8  code of the held key.
- `held_ext`  out  1  extended flag of the held key.
- `press_count`  out  `CNT_W`  number of accepted new presses, wraps modulo 2^`CNT_W`.
- `err_proto`  out  1  sticky: illegal prefix sequence, or keyboard error byte `00`/`FF`.

## Operation
- **FSM states:** S_IDLE, S_POP, S_PARSE.
- **S_IDLE:** if `ready` && (!`ev_valid` || `ev_ready`), then capture `data` into `byte_r`, drive `nextdata_n`<=0, go to S_POP. Otherwise stay.
- **S_POP:** `nextdata_n` is low for this cycle and the FIFO pops at its end. `nextdata_n`<=1, go to S_PARSE.
- **S_PARSE:** classify `byte_r`, then go to S_IDLE.
  - `E0`: if `brk_f`=1, set `err_proto` and clear both flags. Otherwise `ext_f`<=1. No event.
  - `F0`: if `brk_f`=1, set `err_proto` and clear both flags. Otherwise `brk_f`<=1. No event.
  - `00` or `FF`: set `err_proto`, clear both flags, no event.
  - Any other byte is key code K with e=`ext_f`, b=`brk_f`. Flags clear after use.
    - Make (b=0) with `held` && `held_code`==K && `held_ext`==e: typematic repeat, no event, nothing changes.
    - Make otherwise: emit event (K,e,0). `held`<=1, `held_code`<=K, `held_ext`<=e, `press_count`+1.
    - Break (b=1): emit event (K,e,1). If it matches the held key, `held`<=0. A break of a non-held key leaves `held` unchanged.
- **Emit:** load `ev_code`/`ev_ext`/`ev_break` and set `ev_valid`<=1.
  - `ev_valid` clears on the edge where `ev_valid`&&`ev_ready`.
  - Event fields stay stable while `ev_valid`=1 && !`ev_ready`.
  - A fetch is gated in S_IDLE, so S_PARSE never meets an occupied output slot.
- **Backpressure:** a stalled consumer stops FIFO pops. The FIFO absorbs the bytes, and FIFO overflow belongs to the FIFO.
- **`err_proto`:** cleared only by reset.
- **`press_count`:** plain binary wrap, no saturation.

## Timing
- **Reset values:** all outputs reset asynchronously.
  - `nextdata_n`=1.
  - `ev_valid`, `ev_code`, `ev_ext`, `ev_break` = 0.
  - `held`, `held_code`, `held_ext` = 0; `press_count`=0; `err_proto`=0.
  - FSM returns to S_IDLE with `ext_f`=`brk_f`=0.
- **All outputs are registered.** `nextdata_n` comes straight from a flop.
- **Byte cadence:** a byte sampled in S_IDLE at edge t produces `nextdata_n`=0 during cycle t..t+1. The event or prefix update lands at edge t+2, so `ev_valid` is visible from t+2.
- **Throughput:** at most one byte per 3 cycles, and `ready` is never re-sampled before the pop takes effect.
- **Accept and fetch:** `ev_valid`&&`ev_ready` in S_IDLE with `ready`=1 both accepts the event and starts the next fetch on the same edge.
- **Reset mid-operation:** `clrn` low in S_POP or S_PARSE discards `byte_r` and any partial prefix immediately, and no event is emitted.

## Test plan
1. **Make/break A.**
   - Stimulus: FIFO bytes `1C`,`F0`,`1C`; `ev_ready`=1.
   - Response: events (`1C`,ext0,brk0) then (`1C`,ext0,brk1).
   - Three single-cycle `nextdata_n` pulses, 3 cycles apart.
   - `held` goes 1 then 0; `press_count`=1.
2. **Typematic.**
   - Stimulus: `1C`,`1C`,`1C`,`F0`,`1C`.
   - Response: exactly 2 events; `press_count`=1.
3. **Extended and two keys.**
   - Stimulus: `E0`,`75`,`1C`,`E0`,`F0`,`75`.
   - Response: events (`75`,1,0), (`1C`,0,0), (`75`,1,1).
   - `held_code` stays `1C` with `held`=1; `press_count`=2.
4. **Backpressure.**
   - Stimulus: hold `ev_ready`=0 after the first event; FIFO holds 4 bytes.
   - Response: `nextdata_n` stays 1, event fields are constant, and `ready` stays 1.
   - Releasing `ev_ready` drains the remaining bytes with correct events.
5. **Errors.**
   - `F0`,`F0`,`1C`: `err_proto`=1, then `1C` is treated as a make event (`1C`,0,0).
   - `00`: `err_proto` stays 1 and no event is produced.
6. **Reset and wrap.**
   - `clrn` pulsed low during S_POP: all outputs reset in the same cycle, with no clock edge needed.
   - Afterwards, 256 distinct-alternating makes give `press_count` wrapping to 0 when `CNT_W`=8.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// PS/2 receive-FIFO sequencer: pops scan-code bytes, strips E0/F0 prefixes,
// drops typematic repeats of the held key and presents key events on a valid/ready port.
module ps2_key_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready_i,
  input  logic [7:0]       data_i,
  output logic             nextdata_n_o,
  output logic             ev_valid_o,
  input  logic             ev_ready_i,
  output logic [7:0]       ev_code_o,
  output logic             ev_ext_o,
  output logic             ev_break_o,
  output logic             held_o,
  output logic [7:0]       held_code_o,
  output logic             held_ext_o,
  output logic [CNT_W-1:0] press_count_o,
  output logic             err_proto_o
);

  // state   | meaning
  // S_IDLE  | wait for a FIFO byte and a free event slot
  // S_POP   | nextdata_n low, FIFO pops at the end of this cycle
  // S_PARSE | classify the captured byte, update prefixes / emit event
  typedef enum logic [1:0] {S_IDLE, S_POP, S_PARSE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic               ext_f_q, ext_f_d;
  logic               brk_f_q, brk_f_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               ev_valid_q, ev_valid_d;
  logic [7:0]         ev_code_q, ev_code_d;
  logic               ev_ext_q, ev_ext_d;
  logic               ev_break_q, ev_break_d;
  logic               held_q, held_d;
  logic [7:0]         held_code_q, held_code_d;
  logic               held_ext_q, held_ext_d;
  logic [CNT_W-1:0]   press_count_q, press_count_d;
  logic               err_proto_q, err_proto_d;
  logic               held_match;

  assign held_match = held_q && (held_code_q == byte_q) && (held_ext_q == ext_f_q);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= S_IDLE;
      byte_q        <= 8'h00;
      ext_f_q       <= 1'b0;
      brk_f_q       <= 1'b0;
      nextdata_n_q  <= 1'b1;
      ev_valid_q    <= 1'b0;
      ev_code_q     <= 8'h00;
      ev_ext_q      <= 1'b0;
      ev_break_q    <= 1'b0;
      held_q        <= 1'b0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
      press_count_q <= '0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      ext_f_q       <= ext_f_d;
      brk_f_q       <= brk_f_d;
      nextdata_n_q  <= nextdata_n_d;
      ev_valid_q    <= ev_valid_d;
      ev_code_q     <= ev_code_d;
      ev_ext_q      <= ev_ext_d;
      ev_break_q    <= ev_break_d;
      held_q        <= held_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      press_count_q <= press_count_d;
      err_proto_q   <= err_proto_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    ext_f_d       = ext_f_q;
    brk_f_d       = brk_f_q;
    nextdata_n_d  = nextdata_n_q;
    ev_valid_d    = ev_valid_q;
    ev_code_d     = ev_code_q;
    ev_ext_d      = ev_ext_q;
    ev_break_d    = ev_break_q;
    held_d        = held_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    press_count_d = press_count_q;
    err_proto_d   = err_proto_q;

    if (ev_valid_q && ev_ready_i) ev_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Fetch only when the slot is free or being freed on this edge.
        if (ready_i && (!ev_valid_q || ev_ready_i)) begin
          byte_d       = data_i;
          nextdata_n_d = 1'b0;
          state_d      = S_POP;
        end
      end
      S_POP: begin
        nextdata_n_d = 1'b1;
        state_d      = S_PARSE;
      end
      S_PARSE: begin
        state_d = S_IDLE;
        case (byte_q)
          8'hE0, 8'hF0: begin
            if (brk_f_q) begin
              err_proto_d = 1'b1;
              ext_f_d     = 1'b0;
              brk_f_d     = 1'b0;
            end else if (byte_q == 8'hE0) begin
              ext_f_d = 1'b1;
            end else begin
              brk_f_d = 1'b1;
            end
          end
          8'h00, 8'hFF: begin
            err_proto_d = 1'b1;
            ext_f_d     = 1'b0;
            brk_f_d     = 1'b0;
          end
          default: begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
            if (brk_f_q) begin
              ev_valid_d = 1'b1;
              ev_code_d  = byte_q;
              ev_ext_d   = ext_f_q;
              ev_break_d = 1'b1;
              if (held_match) held_d = 1'b0;
            end else if (!held_match) begin
              ev_valid_d    = 1'b1;
              ev_code_d     = byte_q;
              ev_ext_d      = ext_f_q;
              ev_break_d    = 1'b0;
              held_d        = 1'b1;
              held_code_d   = byte_q;
              held_ext_d    = ext_f_q;
              press_count_d = press_count_q + CNT_W'(1);
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign nextdata_n_o  = nextdata_n_q;
  assign ev_valid_o    = ev_valid_q;
  assign ev_code_o     = ev_code_q;
  assign ev_ext_o      = ev_ext_q;
  assign ev_break_o    = ev_break_q;
  assign held_o        = held_q;
  assign held_code_o   = held_code_q;
  assign held_ext_o    = held_ext_q;
  assign press_count_o = press_count_q;
  assign err_proto_o   = err_proto_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: queue-based FIFO model feeding the DUT and a
// byte-stream reference model producing the expected events and key state.
module tb_ps2_key_sequencer;
  logic       clk, clrn, ready_i, nextdata_n_o, ev_valid_o, ev_ready_i;
  logic [7:0] data_i, ev_code_o, held_code_o, press_count_o;
  logic       ev_ext_o, ev_break_o, held_o, held_ext_o, err_proto_o;

  ps2_key_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ready_i(ready_i), .data_i(data_i),
    .nextdata_n_o(nextdata_n_o), .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i),
    .ev_code_o(ev_code_o), .ev_ext_o(ev_ext_o), .ev_break_o(ev_break_o),
    .held_o(held_o), .held_code_o(held_code_o), .held_ext_o(held_ext_o),
    .press_count_o(press_count_o), .err_proto_o(err_proto_o));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0, n_err = 0, cyc = 0, n_wide = 0;
  logic [7:0] fifo[$];
  logic [9:0] exp_ev[$], got[$];
  int pops[$];
  bit prev_low, saw_held;

  // reference key-state model
  bit m_ext, m_brk, m_held, m_hext, m_err;
  logic [7:0] m_hcode, m_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_err = 0; m_hcode = 0; m_cnt = 0;
    exp_ev.delete();
  endtask

  task automatic feed(logic [7:0] b);
    bit e, br, same;
    if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) begin m_err = 1; m_ext = 0; m_brk = 0; end
      else if (b == 8'hE0) m_ext = 1;
      else m_brk = 1;
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1; m_ext = 0; m_brk = 0;
    end else begin
      e = m_ext; br = m_brk; m_ext = 0; m_brk = 0;
      same = m_held && m_hcode == b && m_hext == e;
      if (br) begin
        exp_ev.push_back({b, e, 1'b1});
        if (same) m_held = 0;
      end else if (!same) begin
        exp_ev.push_back({b, e, 1'b0});
        m_held = 1; m_hcode = b; m_hext = e; m_cnt = m_cnt + 8'd1;
      end
    end
  endtask

  task automatic refresh();
    ready_i = (fifo.size() != 0);
    data_i  = ready_i ? fifo[0] : 8'h00;
  endtask

  task automatic push(logic [7:0] b);
    fifo.push_back(b);
    feed(b);
    refresh();
  endtask

  task automatic cycle();
    bit pop_now;
    pop_now = !nextdata_n_o;
    if (ev_valid_o && ev_ready_i) got.push_back({ev_code_o, ev_ext_o, ev_break_o});
    if (pop_now) begin
      pops.push_back(cyc);
      if (prev_low) n_wide++;
    end
    prev_low = pop_now;
    if (held_o) saw_held = 1;
    @(posedge clk); #1;
    cyc++;
    if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    clrn = 0; ev_ready_i = 0;
    fifo.delete(); refresh(); model_reset();
    got.delete(); pops.delete(); n_wide = 0; saw_held = 0; prev_low = 0;
    repeat (2) @(posedge clk);
    #1 clrn = 1;
  endtask

  task automatic run(int mode, string tag);
    int idle = 0;
    bit done = 0;
    for (int i = 0; i < 5000; i++) begin
      ev_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle();
      if (fifo.size() == 0 && nextdata_n_o && !ev_valid_o) idle++;
      else idle = 0;
      if (idle >= 4) begin done = 1; break; end
    end
    chk({tag, " drain"}, done, 1);
  endtask

  task automatic check_events(string tag);
    int n;
    chk({tag, " nev"}, got.size(), exp_ev.size());
    n = (got.size() < exp_ev.size()) ? got.size() : exp_ev.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s ev%0d", tag, i), got[i], exp_ev[i]);
    chk({tag, " held"}, held_o, m_held);
    chk({tag, " held_code"}, held_o ? held_code_o : 8'h0, m_held ? m_hcode : 8'h0);
    chk({tag, " cnt"}, press_count_o, m_cnt);
    chk({tag, " err"}, err_proto_o, m_err);
    got.delete(); exp_ev.delete();
  endtask

  initial begin
    logic [9:0] snap;
    bit bad, found;
    logic [7:0] pool [8];
    clrn = 1; ev_ready_i = 0; ready_i = 0; data_i = 0;
    #2;
    do_reset();
    chk("rst nextdata_n", nextdata_n_o, 1);
    chk("rst ev", {ev_valid_o, ev_code_o, ev_ext_o, ev_break_o}, 0);
    chk("rst held", {held_o, held_code_o, held_ext_o}, 0);
    chk("rst cnt/err", {press_count_o, err_proto_o}, 0);

    // 1: make/break, pop cadence
    push(8'h1C); push(8'hF0); push(8'h1C);
    run(0, "t1");
    chk("t1 pops", pops.size(), 3);
    if (pops.size() == 3) begin
      chk("t1 gap0", pops[1] - pops[0], 3);
      chk("t1 gap1", pops[2] - pops[1], 3);
    end
    chk("t1 wide", n_wide, 0);
    chk("t1 saw_held", saw_held, 1);
    check_events("t1");

    // 2: typematic
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    run(0, "t2");
    chk("t2 two events", got.size(), 2);
    check_events("t2");

    // 3: extended and two keys
    do_reset();
    push(8'hE0); push(8'h75); push(8'h1C); push(8'hE0); push(8'hF0); push(8'h75);
    run(0, "t3");
    chk("t3 held_code", held_code_o, 8'h1C);
    chk("t3 cnt", press_count_o, 2);
    check_events("t3");

    // 4: backpressure
    do_reset();
    push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C); push(8'h2A);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cycle(); found = ev_valid_o; end
    chk("t4 first ev", found, 1);
    snap = {ev_code_o, ev_ext_o, ev_break_o};
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (!nextdata_n_o || !ev_valid_o || {ev_code_o, ev_ext_o, ev_break_o} !== snap) bad = 1;
    end
    chk("t4 stalled stable", bad, 0);
    chk("t4 fifo kept", fifo.size(), 4);
    chk("t4 ready", ready_i, 1);
    run(0, "t4");
    check_events("t4");

    // 5: protocol errors
    do_reset();
    push(8'hF0); push(8'hF0); push(8'h1C);
    run(0, "t5a");
    chk("t5 err", err_proto_o, 1);
    chk("t5 make", got.size() == 1 ? got[0] : 10'h3FF, {8'h1C, 2'b00});
    check_events("t5a");
    push(8'h00);
    run(0, "t5b");
    chk("t5 no ev", got.size(), 0);
    check_events("t5b");

    // 6: async reset during S_POP, then counter wrap
    push(8'h1C);
    run(0, "t6a");
    check_events("t6a");
    push(8'h2A);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      ev_ready_i = 1; cycle(); found = !nextdata_n_o;
    end
    chk("t6 in pop", found, 1);
    #2 clrn = 0;
    #1;
    chk("t6 async nextdata_n", nextdata_n_o, 1);
    chk("t6 async ev", {ev_valid_o, ev_code_o, ev_ext_o, ev_break_o}, 0);
    chk("t6 async held", {held_o, held_code_o, held_ext_o}, 0);
    chk("t6 async cnt/err", {press_count_o, err_proto_o}, 0);
    do_reset();
    for (int i = 0; i < 256; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
    run(1, "t6w");
    chk("t6 wrap", press_count_o, 0);
    check_events("t6w");

    // 7: random byte stream with random consumer stalls
    do_reset();
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C; pool[3] = 8'h32;
    pool[4] = 8'h75; pool[5] = 8'h2A; pool[6] = 8'h00; pool[7] = 8'hFF;
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 19);
      push(pool[(k < 6) ? 2 + (k % 4) : (k < 11) ? 1 : (k < 15) ? 0 : (k == 15) ? 6 + (k % 2) : 2 + (k % 4)]);
    end
    run(1, "t7");
    check_events("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
